// File: rtl/bsg_cgol_ctrl_if.sv
// Host-side job channel of the Game-of-Life controller: board/frame-count request
// (valid/ready) and final-board response (valid/yumi).
interface bsg_cgol_ctrl_if #(
   parameter int board_width_p  = 8,
   parameter int frames_width_p = 16
);
   localparam int cells_lp = board_width_p * board_width_p;

   logic [cells_lp-1:0]       data_i;
   logic [frames_width_p-1:0] frames_i;
   logic                      v_i;
   logic                      ready_o;
   logic [cells_lp-1:0]       data_o;
   logic                      v_o;
   logic                      yumi_i;

   // master = host/FIFO side, slave = controller
   modport master (
      output data_i, frames_i, v_i, yumi_i,
      input  ready_o, data_o, v_o
   );

   modport slave (
      input  data_i, frames_i, v_i, yumi_i,
      output ready_o, data_o, v_o
   );
endinterface

// File: rtl/bsg_cgol_ctrl.sv
// Game-of-Life sequencer: loads a board into the cell array, runs N generations, returns the result.
// Optional macro BSG_CGOL_CTRL_STEP_DIV_EN spaces en_o pulses step_div_p cycles apart.
module bsg_cgol_ctrl #(
   parameter int board_width_p  = 8,
   parameter int frames_width_p = 16,
   parameter int step_div_p     = 4
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   bsg_cgol_ctrl_if.slave                           host_if,
   output logic                                     update_o,
   output logic [board_width_p*board_width_p-1:0]   update_val_o,
   output logic                                     en_o,
   input  logic [board_width_p*board_width_p-1:0]   cells_i,
   output logic [frames_width_p-1:0]                gen_cnt_o
);

   localparam int cells_lp = board_width_p * board_width_p;

   if (step_div_p < 2 || step_div_p > 256) begin : g_bad_div
      $error("bsg_cgol_ctrl: step_div_p must be within 2..256");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SIM,
      ST_DONE
   } state_e;

   state_e                     r_state;
   state_e                     w_state_nxt;
   logic                       r_ready;
   logic                       r_update;
   logic                       r_en;
   logic                       r_v;
   logic [cells_lp-1:0]        r_update_val;
   logic [frames_width_p-1:0]  r_remain;
   logic [frames_width_p-1:0]  r_gen;
   logic                       w_accept;
   logic                       w_last;
   logic                       w_en_nxt;

   assign w_accept = host_if.v_i & r_ready;
   assign w_last   = (r_remain == frames_width_p'(1));

   // NOTE: combinational blocks assign every output a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
         ST_LOAD: w_state_nxt = (r_remain == '0) ? ST_DONE : ST_SIM;
         ST_SIM:  if (r_en && w_last) w_state_nxt = ST_DONE;
         ST_DONE: if (host_if.yumi_i) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef BSG_CGOL_CTRL_STEP_DIV_EN
   localparam int                   presc_w_lp    = $clog2(step_div_p);
   localparam logic [presc_w_lp-1:0] presc_last_lp = presc_w_lp'(step_div_p - 1);

   logic [presc_w_lp-1:0] r_presc;
   logic [presc_w_lp-1:0] w_presc_nxt;

   // Prescaler restarts from 0 on every SIM entry; the pulse lands on its terminal count.
   always_comb begin
      w_presc_nxt = '0;
      if (r_state == ST_SIM && w_state_nxt == ST_SIM) begin
         w_presc_nxt = (r_presc == presc_last_lp) ? '0 : r_presc + presc_w_lp'(1);
      end
   end

   assign w_en_nxt = (w_state_nxt == ST_SIM) && (w_presc_nxt == presc_last_lp);
`else
   assign w_en_nxt = (w_state_nxt == ST_SIM);
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= ST_IDLE;
         r_ready      <= 1'b0;
         r_update     <= 1'b0;
         r_en         <= 1'b0;
         r_v          <= 1'b0;
         r_update_val <= '0;
         r_remain     <= '0;
         r_gen        <= '0;
`ifdef BSG_CGOL_CTRL_STEP_DIV_EN
         r_presc      <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ready  <= (w_state_nxt == ST_IDLE);
         r_update <= (w_state_nxt == ST_LOAD);
         r_v      <= (w_state_nxt == ST_DONE);
         r_en     <= w_en_nxt;
`ifdef BSG_CGOL_CTRL_STEP_DIV_EN
         r_presc  <= w_presc_nxt;
`endif
         if (w_accept) begin
            r_update_val <= host_if.data_i;
            r_remain     <= host_if.frames_i;
            r_gen        <= '0;
         end else if (r_en) begin
            // r_en is only ever high while r_remain >= 1, so the decrement cannot wrap
            r_remain <= r_remain - frames_width_p'(1);
            if (r_gen != '1) r_gen <= r_gen + frames_width_p'(1);
         end
      end
   end

   assign host_if.ready_o = r_ready;
   assign host_if.v_o     = r_v;
   assign host_if.data_o  = r_v ? cells_i : '0;
   assign update_o        = r_update;
   assign update_val_o    = r_update_val;
   assign en_o            = r_en;
   assign gen_cnt_o       = r_gen;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Self-checking bench for bsg_cgol_ctrl: behavioural cell arrays plus a Game-of-Life reference model.
module tb_bsg_cgol_ctrl;

   localparam int BW    = 8;
   localparam int N     = BW * BW;
   localparam int FW    = 16;
   localparam int FW4   = 4;
   localparam int DIV_P = 4;
`ifdef BSG_CGOL_CTRL_STEP_DIV_EN
   localparam int DIV = DIV_P;
`else
   localparam int DIV = 1;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   bsg_cgol_ctrl_if #(.board_width_p(BW), .frames_width_p(FW))  h ();
   bsg_cgol_ctrl_if #(.board_width_p(BW), .frames_width_p(FW4)) h4 ();

   logic           upd, en, upd4, en4;
   logic [N-1:0]   uval, uval4;
   logic [N-1:0]   cells  = '0;
   logic [N-1:0]   cells4 = '0;
   logic [FW-1:0]  gen;
   logic [FW4-1:0] gen4;

   bsg_cgol_ctrl #(.board_width_p(BW), .frames_width_p(FW), .step_div_p(DIV_P)) u_dut (
      .clk_i(clk), .reset_n_i(rst_n), .host_if(h),
      .update_o(upd), .update_val_o(uval), .en_o(en), .cells_i(cells), .gen_cnt_o(gen)
   );

   bsg_cgol_ctrl #(.board_width_p(BW), .frames_width_p(FW4), .step_div_p(DIV_P)) u_dut4 (
      .clk_i(clk), .reset_n_i(rst_n), .host_if(h4),
      .update_o(upd4), .update_val_o(uval4), .en_o(en4), .cells_i(cells4), .gen_cnt_o(gen4)
   );

   // One generation of Life on a bounded board; cells outside the board are dead.
   function automatic logic [N-1:0] life(input logic [N-1:0] b);
      logic [N-1:0] nb;
      int cnt;
      nb = '0;
      for (int r = 0; r < BW; r++) begin
         for (int c = 0; c < BW; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < BW && c + dc >= 0 && c + dc < BW)
                     cnt += int'(b[(r + dr) * BW + c + dc]);
               end
            end
            nb[r * BW + c] = (cnt == 3) || (b[r * BW + c] && cnt == 2);
         end
      end
      return nb;
   endfunction

   function automatic logic [N-1:0] life_n(input logic [N-1:0] b, input int n);
      logic [N-1:0] x;
      x = b;
      for (int i = 0; i < n; i++) x = life(x);
      return x;
   endfunction

   // Cell arrays driven by the controllers' shared nets.
   always @(posedge clk) begin
      if (upd) cells <= uval;
      else if (en) cells <= life(cells);
   end

   always @(posedge clk) begin
      if (upd4) cells4 <= uval4;
      else if (en4) cells4 <= life(cells4);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input string tag, input logic [N-1:0] board, input logic [FW-1:0] frames,
                          input int hold, output logic [N-1:0] got);
      int lat, ens, first_en, limit, w;
      logic [N-1:0] exp_b;
      exp_b = life_n(board, int'(frames));
      w = 0;
      while (!h.ready_o && w < 50) begin tick(); w++; end
      check({tag, " ready"}, 64'(h.ready_o), 64'(1));
      h.data_i = board; h.frames_i = frames; h.v_i = 1'b1;
      tick();
      h.v_i = 1'b0; h.data_i = ~board; h.frames_i = ~frames;
      check({tag, " update"}, 64'(upd), 64'(1));
      lat = 1; ens = 0; first_en = 0; limit = 2 + int'(frames) * DIV + 20;
      while (!h.v_o && lat < limit) begin
         if (en) begin
            ens++;
            if (first_en == 0) first_en = lat;
         end
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(2 + int'(frames) * DIV));
      check({tag, " en_count"}, 64'(ens), 64'(frames));
      if (frames != '0) check({tag, " first_en"}, 64'(first_en), 64'(1 + DIV));
      check({tag, " board"}, h.data_o, exp_b);
      check({tag, " gen_cnt"}, 64'(gen), 64'(frames));
      got = h.data_o;
      for (int i = 0; i < hold; i++) begin
         h.v_i = 1'b1; h.data_i = {$urandom, $urandom}; h.frames_i = FW'($urandom);
         check({tag, " hold v_o"}, 64'(h.v_o), 64'(1));
         check({tag, " hold en_o"}, 64'(en), 64'(0));
         check({tag, " hold ready_o"}, 64'(h.ready_o), 64'(0));
         check({tag, " hold board"}, h.data_o, exp_b);
         tick();
      end
      h.v_i = 1'b0;
      check({tag, " update_val kept"}, uval, board);
      h.yumi_i = 1'b1;
      check({tag, " ready in yumi cycle"}, 64'(h.ready_o), 64'(0));
      tick();
      h.yumi_i = 1'b0;
      check({tag, " ready after yumi"}, 64'(h.ready_o), 64'(1));
      check({tag, " v_o after yumi"}, 64'(h.v_o), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] blink, vert, glider, glider4, block, board, got, snap;
      int lat, ens, w;
      h.data_i = '0;  h.frames_i = '0;  h.v_i = 1'b0;  h.yumi_i = 1'b0;
      h4.data_i = '0; h4.frames_i = '0; h4.v_i = 1'b0; h4.yumi_i = 1'b0;

      blink   = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
      vert    = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
      glider  = (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 25) | (64'd1 << 26) | (64'd1 << 27);
      glider4 = (64'd1 << 19) | (64'd1 << 28) | (64'd1 << 34) | (64'd1 << 35) | (64'd1 << 36);
      block   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);

      // Reset state
      #3;
      check("rst ready_o", 64'(h.ready_o), 64'(0));
      check("rst update_o", 64'(upd), 64'(0));
      check("rst en_o", 64'(en), 64'(0));
      check("rst v_o", 64'(h.v_o), 64'(0));
      check("rst update_val_o", uval, 64'(0));
      check("rst gen_cnt_o", 64'(gen), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("post-rst ready_o", 64'(h.ready_o), 64'(1));

      // Blinker: one generation flips it vertical; two (divided build) restore it
      if (DIV > 1) begin
         run_job("blinker", blink, FW'(2), 0, got);
         check("blinker const", got, blink);
      end else begin
         run_job("blinker", blink, FW'(1), 0, got);
         check("blinker const", got, vert);
      end

      // Zero frames: SIM skipped, board passes through untouched
      board = {$urandom, $urandom};
      run_job("zero", board, FW'(0), 0, got);
      check("zero const", got, board);

      // Back-pressure: glider moves (+1,+1) in 4 generations, result held 10 cycles
      run_job("glider", glider, FW'(4), 10, got);
      check("glider const", got, glider4);

      for (int k = 0; k < 4; k++) begin
         run_job("random", {$urandom, $urandom}, FW'($urandom_range(1, 6)), int'($urandom_range(0, 2)), got);
      end

      // Reset asserted in SIM cycle 20 of a 100-frame job
      board = {$urandom, $urandom} | blink;
      w = 0;
      while (!h.ready_o && w < 50) begin tick(); w++; end
      h.data_i = board; h.frames_i = FW'(100); h.v_i = 1'b1;
      tick();
      h.v_i = 1'b0;
      repeat (20) tick();
      check("midrst en before", 64'(en), 64'(1));
      check("midrst gen before", 64'(gen), 64'((20 - 1) / DIV));
      snap = cells;
      rst_n = 1'b0;
      #1;
      check("midrst en_o async", 64'(en), 64'(0));
      check("midrst ready_o", 64'(h.ready_o), 64'(0));
      check("midrst gen_cnt_o", 64'(gen), 64'(0));
      tick();
      tick();
      check("midrst cells frozen", cells, snap);
      rst_n = 1'b1;
      tick();
      check("midrst ready after", 64'(h.ready_o), 64'(1));
      check("midrst gen after", 64'(gen), 64'(0));
      check("midrst v_o after", 64'(h.v_o), 64'(0));
      check("midrst en after", 64'(en), 64'(0));

      // Max count on the 4-bit instance: 15 frames of a still-life block
      w = 0;
      while (!h4.ready_o && w < 50) begin tick(); w++; end
      h4.data_i = block; h4.frames_i = 4'hF; h4.v_i = 1'b1;
      tick();
      h4.v_i = 1'b0;
      lat = 1; ens = 0;
      while (!h4.v_o && lat < 200) begin
         if (en4) ens++;
         tick();
         lat++;
      end
      check("max latency", 64'(lat), 64'(2 + 15 * DIV));
      check("max en_count", 64'(ens), 64'(15));
      check("max gen_cnt", 64'(gen4), 64'(15));
      check("max board", h4.data_o, block);
      h4.yumi_i = 1'b1;
      tick();
      h4.yumi_i = 1'b0;
      check("max ready after", 64'(h4.ready_o), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
